// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the repeated-addition multiplier controller.
// MULT_SEQ_WATCHDOG_EN enables the iteration watchdog in the importing modules.
package mult_ctrl_pkg;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned DEF_ITER_W   = 16;
   localparam int unsigned DEF_MAX_ITER = 32'h0000_FFFF;

   typedef enum logic [2:0] {
      IDLE,
      LDA,
      LDB,
      ADD,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter: clear, increment and optional watchdog limit compare.
// MULT_SEQ_WATCHDOG_EN adds the MAX_ITER compare; otherwise o_at_max_c is tied 0.
module mult_iter_cnt
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned ITER_W = DEF_ITER_W
`ifdef MULT_SEQ_WATCHDOG_EN
   ,parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(DEF_MAX_ITER)
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_inc,
   output logic [ITER_W-1:0] o_cnt,
   output logic              o_at_max_c
);

   logic [ITER_W-1:0] r_cnt;

   // Clear wins over increment; wraps modulo 2^ITER_W
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + ITER_W'(1);
      end
   end

   assign o_cnt = r_cnt;

`ifdef MULT_SEQ_WATCHDOG_EN
   assign o_at_max_c = (r_cnt == MAX_ITER);
`else
   assign o_at_max_c = 1'b0;
`endif

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the repeated-addition multiplier datapath (load A, load B, add/decrement loop).
// MULT_SEQ_WATCHDOG_EN enables the MAX_ITER loop watchdog and the ERR state.
module mult_seq_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned ITER_W = DEF_ITER_W
`ifdef MULT_SEQ_WATCHDOG_EN
   ,parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(DEF_MAX_ITER)
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              eqZ,
   output logic              ldA,
   output logic              ldB,
   output logic              ldP,
   output logic              clrP,
   output logic              decB,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ITER_W-1:0] iter_cnt
);

   state_t r_state;
   logic   r_ldA;
   logic   r_ldB;
   logic   r_clrP;
   logic   r_busy;
   logic   r_done;
`ifdef MULT_SEQ_WATCHDOG_EN
   logic   r_err;
`endif

   logic   w_at_max_c;
   logic   w_add_c;
   logic   w_clr_cnt;

   // ldP/decB must react to eqZ in the same cycle, so the add strobe is Mealy
   assign w_add_c   = (r_state == ADD) && !eqZ && !w_at_max_c;
   assign w_clr_cnt = (r_state == LDB);

   mult_iter_cnt #(
      .ITER_W    (ITER_W)
`ifdef MULT_SEQ_WATCHDOG_EN
     ,.MAX_ITER  (MAX_ITER)
`endif
   ) u_iter_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_clr_cnt),
      .i_inc      (w_add_c),
      .o_cnt      (iter_cnt),
      .o_at_max_c (w_at_max_c)
   );

   // State register plus registered strobes, decoded for the state being entered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ldA   <= 1'b0;
         r_ldB   <= 1'b0;
         r_clrP  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef MULT_SEQ_WATCHDOG_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_ldA  <= 1'b0;
         r_ldB  <= 1'b0;
         r_clrP <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
`ifdef MULT_SEQ_WATCHDOG_EN
         r_err  <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= LDA;
                  r_ldA   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            LDA: begin
               r_state <= LDB;
               r_ldB   <= 1'b1;
               r_clrP  <= 1'b1;
               r_busy  <= 1'b1;
            end
            LDB: begin
               r_state <= ADD;
               r_busy  <= 1'b1;
            end
            ADD: begin
               r_busy <= 1'b1;
               if (eqZ) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
`ifdef MULT_SEQ_WATCHDOG_EN
               else if (w_at_max_c) begin
                  r_state <= ERR;
                  r_err   <= 1'b1;
               end
`endif
            end
            DONE: begin
               r_state <= IDLE;
            end
`ifdef MULT_SEQ_WATCHDOG_EN
            ERR: begin
               r_state <= IDLE;
            end
`endif
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ldA  = r_ldA;
   assign ldB  = r_ldB;
   assign clrP = r_clrP;
   assign busy = r_busy;
   assign done = r_done;
   assign ldP  = w_add_c;
   assign decB = w_add_c;

`ifdef MULT_SEQ_WATCHDOG_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural A/B/P datapath around it.
// Build with MULT_SEQ_WATCHDOG_EN to exercise the watchdog abort path.
module tb_mult_seq_ctrl;
   import mult_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              eqZ;
   logic              ldA, ldB, ldP, clrP, decB, busy, done, err;
   logic [15:0]       iter_cnt;

   logic [DATA_W-1:0] op_a = '0;
   logic [DATA_W-1:0] op_b = '0;
   logic [DATA_W-1:0] m_a = '0;
   logic [DATA_W-1:0] m_b = '0;
   logic [DATA_W-1:0] m_p = '0;
   logic [DATA_W-1:0] bus;
   logic              force_nz = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

`ifdef MULT_SEQ_WATCHDOG_EN
   mult_seq_ctrl #(.ITER_W(16), .MAX_ITER(16'd4)) dut (
`else
   mult_seq_ctrl #(.ITER_W(16)) dut (
`endif
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .eqZ      (eqZ),
      .ldA      (ldA),
      .ldB      (ldB),
      .ldP      (ldP),
      .clrP     (clrP),
      .decB     (decB),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .iter_cnt (iter_cnt)
   );

   // Host drives A while ldA is strobed, otherwise B
   assign bus = ldA ? op_a : op_b;
   assign eqZ = force_nz ? 1'b0 : (m_b == '0);

   always @(posedge clk) begin
      if (ldA)  m_a <= bus;
      if (ldB)  m_b <= bus;
      if (decB) m_b <= m_b - DATA_W'(1);
      if (clrP) m_p <= '0;
      if (ldP)  m_p <= m_p + m_a;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk_eq({tag, "_strobes"}, 32'({ldA, ldB, ldP, clrP, decB, busy, done, err}), 32'd0);
      chk_eq({tag, "_iter"}, 32'(iter_cnt), 32'd0);
   endtask

   // Caller is at a negedge with the DUT in IDLE; start is sampled at the next edge (edge 0)
   task automatic do_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic hold, input int exp_p);
      int cyc;
      int adds;
      int first_add;
      int viol;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(negedge clk);
      cyc = 1;
      if (!hold) start = 1'b0;
      chk_eq({tag, "_ldA_c1"}, 32'({ldA, ldB, clrP, ldP}), 32'b1000);
      @(negedge clk);
      cyc = 2;
      chk_eq({tag, "_ldB_clrP_c2"}, 32'({ldA, ldB, clrP, ldP}), 32'b0110);
      adds = 0;
      first_add = 0;
      viol = 0;
      while (!done && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (ldP) begin
            adds++;
            if (first_add == 0) first_add = cyc;
         end
         if (ldP != decB) viol++;
         if ((ldP || decB) && (ldA || ldB || clrP || err)) viol++;
      end
      chk_eq({tag, "_done_cycle"}, 32'(cyc), 32'(b) + 32'd4);
      chk_eq({tag, "_adds"}, 32'(adds), 32'(b));
      if (b != 16'd0) chk_eq({tag, "_first_add"}, 32'(first_add), 32'd3);
      chk_eq({tag, "_excl"}, 32'(viol), 32'd0);
      chk_eq({tag, "_busy_done"}, 32'(busy), 32'd1);
      chk_eq({tag, "_P"}, 32'(m_p), 32'(exp_p));
      chk_eq({tag, "_iter"}, 32'(iter_cnt), 32'(b));
      @(negedge clk);
      chk_eq({tag, "_post_idle"}, 32'({busy, done, ldA}), 32'd0);
      chk_eq({tag, "_iter_hold"}, 32'(iter_cnt), 32'(b));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("idle_no_start");

      do_mult("a5b3", 16'd5, 16'd3, 1'b0, 15);
      do_mult("a7b0", 16'd7, 16'd0, 1'b0, 0);

      // start held through DONE: one operation, then LDA right after the first IDLE cycle
      do_mult("hold_a2b2", 16'd2, 16'd2, 1'b1, 4);
      do_mult("b2b_a3b4", 16'd3, 16'd4, 1'b0, 12);

      // Reset during the add loop aborts without done
      op_a  = 16'd9;
      op_b  = 16'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_idle_outputs("mid_reset");
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_eq("mid_reset_no_done", 32'({done, busy}), 32'd0);
      end
      do_mult("a9b10", 16'd9, 16'd10, 1'b0, 90);

      force_nz = 1'b1;
      op_a  = 16'd1;
      op_b  = 16'd5;
`ifdef MULT_SEQ_WATCHDOG_EN
      begin
         int cyc;
         int adds;
         int err_cyc;
         int done_seen;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cyc = 1;
         adds = 0;
         err_cyc = 0;
         done_seen = 0;
         while (!err && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ldP && decB) adds++;
            if (done) done_seen++;
         end
         if (err) err_cyc = cyc;
         chk_eq("wd_adds", 32'(adds), 32'd4);
         chk_eq("wd_err_cycle", 32'(err_cyc), 32'd8);
         chk_eq("wd_err_strobes", 32'({ldP, decB, done, busy}), 32'b0001);
         chk_eq("wd_no_done", 32'(done_seen), 32'd0);
         @(negedge clk);
         chk_eq("wd_err_pulse", 32'({err, done, busy}), 32'd0);
         force_nz = 1'b0;
      end
`else
      begin
         int adds;
         int err_seen;
         int busy_low;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         adds = 0;
         err_seen = 0;
         busy_low = 0;
         repeat (20) begin
            @(negedge clk);
            if (ldP && decB) adds++;
            if (err) err_seen++;
            if (!busy) busy_low++;
         end
         @(negedge clk);
         chk_eq("nowd_adds", 32'(adds), 32'd20);
         chk_eq("nowd_err", 32'(err_seen), 32'd0);
         chk_eq("nowd_busy_low", 32'(busy_low), 32'd0);
         chk_eq("nowd_iter", 32'(iter_cnt), 32'd20);
         chk_eq("nowd_still_busy", 32'({busy, err, done}), 32'b100);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         force_nz = 1'b0;
         chk_idle_outputs("nowd_reset");
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
